// File: rtl/link_arbiter.sv
// Round-robin arbiter sharing one req/ack byte link to a slave among NUM_REQ masters.
// A slave that never acks is abandoned after TIMEOUT cycles and the next master is served.
module link_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned TIMEOUT = 16,
   parameter int unsigned CNT_W   = 16,
   localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          m_req,
   input  logic [NUM_REQ*DATA_W-1:0]   m_data,
   output logic [NUM_REQ-1:0]          m_ack,
   output logic                        s_req,
   output logic [DATA_W-1:0]           s_data,
   input  logic                        s_ack,
   output logic                        busy,
   output logic [ID_W-1:0]             grant_id,
   output logic                        done,
   output logic                        err,
   output logic [ID_W-1:0]             err_id,
   output logic [CNT_W-1:0]            xfer_count
);

   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StReq     = 3'd1;
   localparam logic [2:0] StAck     = 3'd2;
   localparam logic [2:0] StRelease = 3'd3;
   localparam logic [2:0] StAbort   = 3'd4;

   logic [2:0]          state_q, state_d;
   logic [ID_W-1:0]     ptr_q, ptr_d;
   logic [ID_W-1:0]     grant_id_q, grant_id_d;
   logic [ID_W-1:0]     err_id_q, err_id_d;
   logic [NUM_REQ-1:0]  m_ack_q, m_ack_d;
   logic [DATA_W-1:0]   s_data_q, s_data_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    xfer_count_q, xfer_count_d;
   logic [TW-1:0]       timer_q, timer_d;

   logic                pick_valid;
   logic [ID_W-1:0]     pick_id;
   logic [ID_W-1:0]     scan_idx;
   logic [ID_W-1:0]     grant_next;

   // First requester at or after ptr, wrapping.
   always_comb begin
      pick_valid = 1'b0;
      pick_id    = ptr_q;
      scan_idx   = ptr_q;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         scan_idx = ID_W'((32'(ptr_q) + i) % NUM_REQ);
         if (!pick_valid && m_req[scan_idx]) begin
            pick_valid = 1'b1;
            pick_id    = scan_idx;
         end
      end
   end

   assign grant_next = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      grant_id_d   = grant_id_q;
      err_id_d     = err_id_q;
      m_ack_d      = m_ack_q;
      s_data_d     = s_data_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      xfer_count_d = xfer_count_q;
      timer_d      = timer_q;
      case (state_q)
         StIdle: begin
            if (pick_valid) begin
               grant_id_d = pick_id;
               s_data_d   = m_data[pick_id*DATA_W +: DATA_W];
               timer_d    = '0;
               state_d    = StReq;
            end
         end
         StReq: begin
            timer_d = timer_q + 1'b1;
            // An ack arriving on the timeout cycle still completes the transfer.
            if (s_ack) begin
               m_ack_d = NUM_REQ'(1) << grant_id_q;
               state_d = StAck;
            end else if (TIMEOUT != 0 && timer_q == TW'(TIMEOUT - 1)) begin
               err_d    = 1'b1;
               err_id_d = grant_id_q;
               ptr_d    = grant_next;
               state_d  = StAbort;
            end
         end
         StAck: begin
            if (!m_req[grant_id_q]) begin
               m_ack_d      = '0;
               done_d       = 1'b1;
               xfer_count_d = xfer_count_q + 1'b1;
               ptr_d        = grant_next;
               state_d      = StRelease;
            end
         end
         StRelease: begin
            if (!s_ack) begin
               state_d = StIdle;
            end
         end
         StAbort: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         ptr_q        <= '0;
         grant_id_q   <= '0;
         err_id_q     <= '0;
         m_ack_q      <= '0;
         s_data_q     <= '0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         xfer_count_q <= '0;
         timer_q      <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         grant_id_q   <= grant_id_d;
         err_id_q     <= err_id_d;
         m_ack_q      <= m_ack_d;
         s_data_q     <= s_data_d;
         done_q       <= done_d;
         err_q        <= err_d;
         xfer_count_q <= xfer_count_d;
         timer_q      <= timer_d;
      end
   end

   assign m_ack      = m_ack_q;
   assign s_req      = (state_q == StReq) || (state_q == StAck);
   assign s_data     = s_data_q;
   assign busy       = (state_q != StIdle);
   assign grant_id   = grant_id_q;
   assign done       = done_q;
   assign err        = err_q;
   assign err_id     = err_id_q;
   assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_link_arbiter.sv
// Bench for link_arbiter: transfer-phase reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_link_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int TO = 16;
   localparam int CW = 16;
   localparam int IW = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NR-1:0]     m_req = '0;
   logic [NR*DW-1:0]  m_data = '0;
   logic              s_ack = 1'b0;
   logic [NR-1:0]     m_ack;
   logic              s_req;
   logic [DW-1:0]     s_data;
   logic              busy;
   logic [IW-1:0]     grant_id;
   logic              done;
   logic              err;
   logic [IW-1:0]     err_id;
   logic [CW-1:0]     xfer_count;

   link_arbiter #(
      .NUM_REQ (NR),
      .DATA_W  (DW),
      .TIMEOUT (TO),
      .CNT_W   (CW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .m_req      (m_req),
      .m_data     (m_data),
      .m_ack      (m_ack),
      .s_req      (s_req),
      .s_data     (s_data),
      .s_ack      (s_ack),
      .busy       (busy),
      .grant_id   (grant_id),
      .done       (done),
      .err        (err),
      .err_id     (err_id),
      .xfer_count (xfer_count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int glog[$];
   logic [DW-1:0] slave_log[$];

   int  want[NR];
   bit  manual[NR];
   bit  slave_en = 1'b1;
   int  ack_delay = 0;
   int  scnt = 0;
   int  spulse = 0;
   bit  sdone = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
   endtask

   // Advances one cycle, then plays the slave and the four-phase masters.
   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         if (rst) begin
            s_ack = 1'b0; scnt = 0; spulse = 0; sdone = 1'b0;
         end else begin
            if (spulse != 0) spulse--;
            if (!s_req) begin
               scnt = 0; sdone = 1'b0;
            end else if (slave_en && !sdone) begin
               if (scnt == ack_delay) begin
                  spulse = 2; sdone = 1'b1; slave_log.push_back(s_data);
               end else begin
                  scnt++;
               end
            end
            s_ack = (spulse != 0);
         end
         for (int i = 0; i < NR; i++) begin
            if (!manual[i]) begin
               if (m_req[i] && m_ack[i]) begin
                  m_req[i] = 1'b0; want[i]--;
               end else if (!m_req[i] && !m_ack[i] && want[i] > 0) begin
                  m_req[i] = 1'b1;
               end
            end
         end
      end
   endtask

   // Reference model: tracks the transfer phase from the inputs seen at each edge.
   initial begin
      bit p_rst, in_req, in_ack, rel, abt, e_done, e_err;
      logic [NR-1:0] p_mreq, e_mack;
      logic [NR*DW-1:0] p_mdata;
      logic p_sack;
      int mptr, mcount, g, eid, reqc;
      logic [DW-1:0] gbyte;
      p_rst = 1'b1; p_mreq = '0; p_mdata = '0; p_sack = 1'b0;
      in_req = 0; in_ack = 0; rel = 0; abt = 0;
      mptr = 0; mcount = 0; g = 0; eid = 0; reqc = 0; gbyte = '0;
      forever begin
         @(negedge clk);
         e_done = 0; e_err = 0;
         if (p_rst) begin
            in_req = 0; in_ack = 0; rel = 0; abt = 0;
            mptr = 0; mcount = 0; g = 0; eid = 0; gbyte = '0;
         end else if (in_req) begin
            if (p_sack) begin
               in_req = 0; in_ack = 1;
            end else if (TO != 0 && reqc == TO) begin
               in_req = 0; abt = 1; e_err = 1; eid = g; mptr = (g + 1) % NR;
            end else begin
               reqc++;
            end
         end else if (in_ack) begin
            if (!p_mreq[g]) begin
               in_ack = 0; rel = 1; e_done = 1;
               mcount = (mcount + 1) % (1 << CW);
               mptr = (g + 1) % NR;
            end
         end else if (rel) begin
            if (!p_sack) rel = 0;
         end else if (abt) begin
            abt = 0;
         end else if (p_mreq != '0) begin
            for (int i = 0; i < NR; i++) begin
               if (!in_req && p_mreq[(mptr + i) % NR]) begin
                  g = (mptr + i) % NR; in_req = 1;
               end
            end
            gbyte = p_mdata[g*DW +: DW];
            reqc = 1;
            glog.push_back(g);
         end
         e_mack = in_ack ? NR'(1 << g) : '0;
         chk("s_req", 32'(s_req), 32'(in_req || in_ack));
         chk("m_ack", 32'(m_ack), 32'(e_mack));
         chk("busy", 32'(busy), 32'(in_req || in_ack || rel || abt));
         chk("done", 32'(done), 32'(e_done));
         chk("err", 32'(err), 32'(e_err));
         chk("grant_id", 32'(grant_id), 32'(g));
         chk("err_id", 32'(err_id), 32'(eid));
         chk("s_data", 32'(s_data), 32'(gbyte));
         chk("xfer_count", 32'(xfer_count), 32'(mcount));
         p_rst = rst; p_mreq = m_req; p_mdata = m_data; p_sack = s_ack;
      end
   end

   initial begin
      int n, acks, dones;
      for (int i = 0; i < NR; i++) begin
         want[i] = 0; manual[i] = 1'b0;
      end
      rst = 1'b1;
      tick(2);
      rst = 1'b0;

      // All four masters at once: served 0,1,2,3.
      m_data = {8'h13, 8'h12, 8'h11, 8'h10};
      glog.delete(); slave_log.delete();
      for (int i = 0; i < NR; i++) want[i] = 1;
      for (int t = 0; t < 100 && xfer_count != 16'd4; t++) tick();
      chk("all4 xfer_count", 32'(xfer_count), 32'd4);
      tick(3);
      chk("all4 grants", 32'(glog.size()), 32'd4);
      for (int i = 0; i < 4 && i < glog.size(); i++) chk("all4 grant order", 32'(glog[i]), 32'(i));
      for (int i = 0; i < 4 && i < slave_log.size(); i++)
         chk("all4 slave byte", 32'(slave_log[i]), 32'(8'h10 + i));

      // Single master 2 with 0xA5, cycle by cycle.
      m_data[2*DW +: DW] = 8'hA5;
      want[2] = 1;
      tick();
      chk("m2 s_req before grant", 32'(s_req), 32'd0);
      tick();
      chk("m2 s_req", 32'(s_req), 32'd1);
      chk("m2 s_data", 32'(s_data), 32'hA5);
      chk("m2 grant_id", 32'(grant_id), 32'd2);
      tick();
      chk("m2 m_ack", 32'(m_ack), 32'b0100);
      tick();
      chk("m2 done", 32'(done), 32'd1);
      chk("m2 xfer_count", 32'(xfer_count), 32'd5);
      chk("m2 s_req released", 32'(s_req), 32'd0);
      tick();
      chk("m2 s_req still low", 32'(s_req), 32'd0);
      chk("m2 done pulse ends", 32'(done), 32'd0);
      chk("m2 slave byte", 32'(slave_log[slave_log.size()-1]), 32'hA5);
      tick(2);

      // Master 1 alone, then 0,1,3 together: 1 must not win twice in a row.
      glog.delete();
      want[1] = 1;
      for (int t = 0; t < 50 && xfer_count != 16'd6; t++) tick();
      tick(3);
      want[0] = 1; want[1] = 1; want[3] = 1;
      for (int t = 0; t < 100 && xfer_count != 16'd9; t++) tick();
      chk("rr xfer_count", 32'(xfer_count), 32'd9);
      tick(3);
      chk("rr grants", 32'(glog.size()), 32'd4);
      if (glog.size() == 4) begin
         chk("rr first", 32'(glog[0]), 32'd1);
         chk("rr second", 32'(glog[1]), 32'd3);
         chk("rr third", 32'(glog[2]), 32'd0);
         chk("rr fourth", 32'(glog[3]), 32'd1);
      end

      // Silent slave: master 3 aborted after 16 REQ cycles, then regranted.
      glog.delete();
      slave_en = 1'b0;
      want[3] = 1;
      for (int t = 0; t < 10 && !s_req; t++) tick();
      chk("to s_req wait", 32'(s_req), 32'd1);
      n = 0;
      for (int t = 0; t < 40 && !err; t++) begin
         tick(); n++;
      end
      chk("to cycles", 32'(n), 32'd16);
      chk("to err_id", 32'(err_id), 32'd3);
      chk("to s_req", 32'(s_req), 32'd0);
      chk("to m_ack", 32'(m_ack), 32'd0);
      chk("to xfer_count", 32'(xfer_count), 32'd9);
      slave_en = 1'b1;
      for (int t = 0; t < 40 && !done; t++) tick();
      chk("to regrant done", 32'(done), 32'd1);
      chk("to regrant id", 32'(grant_id), 32'd3);
      chk("to grants", 32'(glog.size()), 32'd2);
      tick(3);

      // Reset while master 1 holds m_ack.
      manual[1] = 1'b1;
      m_data[1*DW +: DW] = 8'h5C;
      m_req[1] = 1'b1;
      for (int t = 0; t < 20 && !m_ack[1]; t++) tick();
      chk("rst m_ack before", 32'(m_ack), 32'b0010);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst m_ack", 32'(m_ack), 32'd0);
      chk("rst s_req", 32'(s_req), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst xfer_count", 32'(xfer_count), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst err", 32'(err), 32'd0);
      m_req[1] = 1'b0;
      manual[1] = 1'b0;
      want[1] = 1;
      for (int t = 0; t < 40 && !done; t++) tick();
      chk("rst fresh done", 32'(done), 32'd1);
      chk("rst fresh grant", 32'(grant_id), 32'd1);
      chk("rst fresh xfer_count", 32'(xfer_count), 32'd1);
      tick(3);

      // Master 0 withdraws during REQ; late ack still completes it.
      ack_delay = 3;
      m_data[0 +: DW] = 8'h3E;
      want[0] = 1;
      for (int t = 0; t < 10 && !s_req; t++) tick();
      chk("wd s_req wait", 32'(s_req), 32'd1);
      m_req[0] = 1'b0;
      want[0] = 0;
      acks = 0; dones = 0;
      for (int t = 0; t < 12; t++) begin
         tick();
         if (m_ack[0]) acks++;
         if (done) dones++;
      end
      chk("wd m_ack cycles", 32'(acks), 32'd1);
      chk("wd done pulses", 32'(dones), 32'd1);
      chk("wd xfer_count", 32'(xfer_count), 32'd2);
      chk("wd idle", 32'(busy), 32'd0);
      chk("wd slave byte", 32'(slave_log[slave_log.size()-1]), 32'h3E);
      ack_delay = 0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/link_arbiter.md
Name: link_arbiter

Overview:
- Shares one req/ack byte link to a single slave FSM among NUM_REQ masters.
- Each master runs a four-phase req/ack handshake with the arbiter. The arbiter grants one master at a time in round-robin order, forwards that master's byte to the slave, and returns the slave's ack as a clean held m_ack.
- A slave that never acks is caught by a timeout, and the arbiter moves on.
- Sits between the master-side request logic and the slave receiver.

Parameters:
- NUM_REQ, 4, number of masters; must be at least 2.
- DATA_W, 8, byte width on the link.
- TIMEOUT, 16, maximum cycles in REQ before abort; 0 disables the timeout.
- CNT_W, 16, width of xfer_count.
- ID_W, $clog2(NUM_REQ), width of grant_id and err_id (localparam).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- m_req  in  NUM_REQ  per-master request; master i holds its request and data until m_ack[i] is seen.
- m_data  in  NUM_REQ*DATA_W  master i's byte is on bits [i*DATA_W +: DATA_W].
- m_ack  out  NUM_REQ  registered, one-hot or zero; ack to the granted master.
- s_req  out  1  request to slave; decoded from the registered state.
- s_data  out  DATA_W  registered byte to slave; stable while s_req=1.
- s_ack  in  1  slave acknowledge; the slave pulses it 2 cycles.
- busy  out  1  high in any state except IDLE.
- grant_id  out  ID_W  index of the current or last granted master.
- done  out  1  one-cycle pulse when a transfer completes.
- err  out  1  one-cycle pulse on timeout abort.
- err_id  out  ID_W  master index for the last abort.
- xfer_count  out  CNT_W  count of completed transfers; wraps at 2^CNT_W.

Behaviour:
- Reset values:
  - State = IDLE, ptr = 0.
  - m_ack, s_data, grant_id, err_id, done, err, xfer_count all 0; therefore s_req = 0 and busy = 0.
  - Reset mid-transfer drops s_req on the cycle after the reset edge; no done or err is produced.
- States: IDLE, REQ, ACK, RELEASE, ABORT.
- s_req = (state==REQ || state==ACK).
- IDLE:
  - If m_req != 0, pick the first set bit scanning ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - Latch grant_id, latch s_data = that master's m_data slice, clear the timer, go to REQ.
  - Latency: m_req sampled high at edge k gives s_req = 1 after edge k.
- REQ:
  - Timer increments each cycle.
  - s_ack=1 → ACK, set m_ack[grant_id]=1.
  - Otherwise, if TIMEOUT!=0 and timer==TIMEOUT-1 → ABORT.
  - If s_ack and the timeout coincide, s_ack wins.
- ACK:
  - m_ack[grant_id] is held at 1 and s_req stays 1.
  - m_req[grant_id]==0 → RELEASE: clear m_ack, pulse done, increment xfer_count, ptr = grant_id+1 mod NUM_REQ.
  - A master that withdraws its request before the ack still completes; it sees a 1-cycle m_ack and the transfer counts as done.
- RELEASE:
  - s_req=0, held for at least 1 cycle so the slave returns to idle.
  - s_ack==0 → IDLE.
  - No new grant until the arbiter is back in IDLE.
- ABORT (1 cycle):
  - s_req=0, pulse err, err_id=grant_id, ptr = grant_id+1, then go to IDLE.
  - The master gets no m_ack. If its m_req is still high it is re-arbitrated later in fair order.
- Fairness: ptr advances only after done or abort. A master continuously requesting waits at most NUM_REQ-1 transfers.
- m_data and m_req of non-granted masters are ignored. s_data does not change during a transfer even if m_data changes.
- Back-to-back transfers: minimum one RELEASE cycle plus one IDLE cycle between successive s_req highs.

Test Plan:
- Single master 2 requests with m_data=0xA5, others idle:
  - s_req rises the cycle after m_req; slave latches 0xA5.
  - m_ack[2] rises 1 cycle after s_ack.
  - Master drops req → done pulse, xfer_count=1, s_req low ≥1 cycle.
- All four masters request at once and hold their requests; data 0x10,0x11,0x12,0x13:
  - Grants come in order 0,1,2,3; slave last_byte sequence is 0x10..0x13.
  - xfer_count=4; each m_ack is one-hot.
- After master 1 completes, masters 0 and 1 request again:
  - Grant goes to 2 if it is requesting, else 3, else 0; master 1 is never granted twice in a row while others wait.
- Slave held in reset (s_ack stuck 0), TIMEOUT=16, master 3 requests:
  - After exactly 16 cycles in REQ: err pulse, err_id=3, s_req=0, no m_ack.
  - Master 3 is regranted afterwards.
- Assert rst during ACK with m_ack[1]=1:
  - Next cycle all outputs are 0, state IDLE, xfer_count=0.
  - A fresh request from master 1 then completes normally.
- Master 0 drops m_req while in REQ; slave acks 3 cycles later:
  - m_ack[0] pulses 1 cycle, done pulses, xfer_count increments, arbiter returns to IDLE.
